// File: rtl/csd_fft_pkg.sv
// Shared constants for the CSD twiddle sequencer: coefficient selectors and
// the requantisation shift/bias that undo the multiplier's unity scaling.
package csd_fft_pkg;

  localparam int unsigned CSD_NBITS       = 12;
  localparam int unsigned CSD_NBITS_COEFF = 11;
  localparam int unsigned CSD_UNITY_SHIFT = CSD_NBITS_COEFF - 2;
  localparam int unsigned CSD_ROUND_BIAS  = 32'd1 << (CSD_UNITY_SHIFT - 1);

  typedef logic [1:0] csd_sel_t;

  localparam csd_sel_t CSD_SEL_UNITY0 = 2'b00;
  localparam csd_sel_t CSD_SEL_MINUSJ = 2'b01;
  localparam csd_sel_t CSD_SEL_UNITY2 = 2'b10;
  localparam csd_sel_t CSD_SEL_CONST  = 2'b11;

endpackage

// File: rtl/csd_round_sat.sv
// One-component requantiser: add half an LSB, arithmetic shift right, then
// clamp into the signed W_OUT range.
module csd_round_sat
  import csd_fft_pkg::*;
#(
  parameter int unsigned W_IN  = 24,
  parameter int unsigned W_OUT = CSD_NBITS,
  parameter int unsigned SHIFT = CSD_UNITY_SHIFT
) (
  input  logic [W_IN-1:0]  din,
  output logic [W_OUT-1:0] dout_c
);

  // One extra bit so the rounding bias can never wrap the sum
  localparam int unsigned W_EXT = W_IN + 1;
  localparam logic signed [W_EXT-1:0] BIAS  = W_EXT'(64'd1 << (SHIFT - 1));
  localparam logic signed [W_EXT-1:0] MAX_V = W_EXT'((64'd1 << (W_OUT - 1)) - 64'd1);
  localparam logic signed [W_EXT-1:0] MIN_V = ~MAX_V;

  logic signed [W_EXT-1:0] biased;
  logic signed [W_EXT-1:0] shifted;

  always_comb begin
    biased  = $signed({din[W_IN-1], din}) + BIAS;
    shifted = biased >>> SHIFT;
    if (shifted > MAX_V) begin
      dout_c = W_OUT'(MAX_V);
    end else if (shifted < MIN_V) begin
      dout_c = W_OUT'(MIN_V);
    end else begin
      dout_c = W_OUT'(shifted);
    end
  end

endmodule

// File: rtl/csd_twiddle_seq.sv
// Feeds the radix-4 CSD twiddle multiplier with samples and mod-4 selectors,
// then rounds/saturates its wide product back to a valid-tagged NBITS stream.
module csd_twiddle_seq
  import csd_fft_pkg::*;
#(
  parameter int unsigned NBITS      = CSD_NBITS,
  parameter int unsigned NBITScoeff = CSD_NBITS_COEFF,
  parameter int unsigned NBITS_out  = NBITS + NBITScoeff + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_frame_start,
  input  logic [2*NBITS-1:0]     in_data,
  output logic [2*NBITS-1:0]     mult_muestra,
  output logic [1:0]             mult_csd_num_ciclo,
  input  logic [2*NBITS_out-1:0] mult_result,
  output logic                   out_valid,
  output logic                   out_frame_start,
  output logic [2*NBITS-1:0]     out_data
);

  localparam int unsigned SHIFT = NBITScoeff - 2;

  csd_sel_t         cnt;
  csd_sel_t         sel_c;
  logic             v1;
  logic             f1;
  logic [NBITS-1:0] re_c;
  logic [NBITS-1:0] im_c;

  // A frame start forces selector 0 regardless of where the counter sits
  always_comb begin
    sel_c = cnt;
    if (in_frame_start) begin
      sel_c = CSD_SEL_UNITY0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt                <= CSD_SEL_UNITY0;
      v1                 <= 1'b0;
      f1                 <= 1'b0;
      mult_muestra       <= '0;
      mult_csd_num_ciclo <= CSD_SEL_UNITY0;
    end else if (in_valid) begin
      cnt                <= sel_c + 2'd1;
      v1                 <= 1'b1;
      f1                 <= in_frame_start;
      mult_muestra       <= in_data;
      mult_csd_num_ciclo <= sel_c;
    end else begin
      v1 <= 1'b0;
      f1 <= 1'b0;
    end
  end

  csd_round_sat #(
    .W_IN  (NBITS_out),
    .W_OUT (NBITS),
    .SHIFT (SHIFT)
  ) u_round_re (
    .din    (mult_result[2*NBITS_out-1:NBITS_out]),
    .dout_c (re_c)
  );

  csd_round_sat #(
    .W_IN  (NBITS_out),
    .W_OUT (NBITS),
    .SHIFT (SHIFT)
  ) u_round_im (
    .din    (mult_result[NBITS_out-1:0]),
    .dout_c (im_c)
  );

  // Output stage holds its data across bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_frame_start <= 1'b0;
      out_data        <= '0;
    end else begin
      out_valid       <= v1;
      out_frame_start <= f1 & v1;
      if (v1) begin
        out_data <= {re_c, im_c};
      end
    end
  end

endmodule
